div_norm_ctrl: RTL and testbench

//  Parametrised sequencing controller for the iterative radix-2 divider.

---
 rtl/div_norm_ctrl.sv | 130 +++++++++++++
 tb/tb_div_norm_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_norm_ctrl.sv
// Sequencing controller for an iterative radix-2 divider: captures and normalises
// operands, runs the iteration count, short-circuits trivial cases, hands off result.
module div_norm_ctrl #(
  parameter int WIDTH   = 32,
  parameter bit NORM_EN = 1'b1,
  parameter int CNT_W   = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   u_dividend,
  input  logic [WIDTH-1:0]   u_divisor,
  output logic               busy,
  output logic [2*WIDTH-1:0] init_val,
  output logic               ld,
  output logic               sl,
  output logic [CNT_W-1:0]   iter_cnt,
  output logic [CNT_W-1:0]   q_shift,
  output logic               div_zero,
  output logic               quo_zero,
  output logic               res_valid,
  input  logic               res_ready
);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ITER, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [2*WIDTH-1:0] r_init;
  logic [CNT_W-1:0]   r_lz_a, r_lz_b, r_iter_cnt, r_q_shift;
  logic               r_b_zero, r_div_zero, r_quo_zero;

  logic [CNT_W-1:0]   w_lz_a, w_lz_b, w_diff, w_n_iter;
  logic [WIDTH-1:0]   w_a_n, w_b_n;
  logic               w_accept, w_short_qz;

  function automatic logic [CNT_W-1:0] f_lzc(input logic [WIDTH-1:0] x);
    logic found;
    f_lzc = CNT_W'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH-1; i >= 0; i--) begin
      if (!found && x[i]) begin
        f_lzc = CNT_W'(WIDTH-1-i);
        found = 1'b1;
      end
    end
  endfunction

  // Operands are normalised at capture so init_val is already stable when ld fires.
  assign w_lz_a     = f_lzc(u_dividend);
  assign w_lz_b     = f_lzc(u_divisor);
  assign w_a_n      = NORM_EN ? (u_dividend << w_lz_a) : u_dividend;
  assign w_b_n      = NORM_EN ? (u_divisor  << w_lz_b) : u_divisor;
  assign w_accept   = (r_state == S_IDLE) && start && !abort;
  assign w_diff     = r_lz_b - r_lz_a;
  assign w_n_iter   = NORM_EN ? (w_diff + CNT_W'(1)) : CNT_W'(WIDTH);
  assign w_short_qz = NORM_EN && (r_lz_b < r_lz_a);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort && r_state != S_IDLE) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_next = S_NORM;
        S_NORM: w_next = (r_b_zero || w_short_qz) ? S_DONE : S_ITER;
        S_ITER: if (r_iter_cnt == CNT_W'(1)) w_next = S_DONE;
        S_DONE: if (res_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_init     <= '0;
      r_lz_a     <= '0;
      r_lz_b     <= '0;
      r_iter_cnt <= '0;
      r_q_shift  <= '0;
      r_b_zero   <= 1'b0;
      r_div_zero <= 1'b0;
      r_quo_zero <= 1'b0;
    end else if (abort && r_state != S_IDLE) begin
      r_iter_cnt <= '0;
      r_div_zero <= 1'b0;
      r_quo_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_init     <= {w_a_n, w_b_n};
          r_lz_a     <= w_lz_a;
          r_lz_b     <= w_lz_b;
          r_b_zero   <= (u_divisor == '0);
          r_q_shift  <= '0;
          r_div_zero <= 1'b0;
          r_quo_zero <= 1'b0;
        end
        S_NORM: begin
          if (r_b_zero) begin
            r_div_zero <= 1'b1;
          end else if (w_short_qz) begin
            r_quo_zero <= 1'b1;
          end else begin
            r_iter_cnt <= w_n_iter;
            r_q_shift  <= NORM_EN ? w_diff : '0;
          end
        end
        S_ITER: r_iter_cnt <= r_iter_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign ld        = (r_state == S_NORM);
  assign sl        = (r_state == S_ITER);
  assign res_valid = (r_state == S_DONE);
  assign init_val  = r_init;
  assign iter_cnt  = r_iter_cnt;
  assign q_shift   = r_q_shift;
  assign div_zero  = r_div_zero;
  assign quo_zero  = r_quo_zero;

endmodule

// File: tb/tb_div_norm_ctrl.sv
// Scoreboard bench for div_norm_ctrl at WIDTH=8, normalising and non-normalising builds.
module tb_div_norm_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort, res_ready;
  logic [W-1:0]  a, b;
  logic          busy, ld, sl, div_zero, quo_zero, res_valid;
  logic [2*W-1:0] init_val;
  logic [CW-1:0] iter_cnt, q_shift;

  logic          start2, abort2, res_ready2;
  logic [W-1:0]  a2, b2;
  logic          busy2, ld2, sl2, div_zero2, quo_zero2, res_valid2;
  logic [2*W-1:0] init_val2;
  logic [CW-1:0] iter_cnt2, q_shift2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2*W-1:0] init;
    logic           dz;
    logic           qz;
    logic [CW-1:0]  qs;
    int             nsl;
    int             lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  div_norm_ctrl #(.WIDTH(W), .NORM_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .u_dividend(a), .u_divisor(b), .busy(busy), .init_val(init_val),
    .ld(ld), .sl(sl), .iter_cnt(iter_cnt), .q_shift(q_shift),
    .div_zero(div_zero), .quo_zero(quo_zero), .res_valid(res_valid),
    .res_ready(res_ready)
  );

  div_norm_ctrl #(.WIDTH(W), .NORM_EN(1'b0)) dut_nn (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .u_dividend(a2), .u_divisor(b2), .busy(busy2), .init_val(init_val2),
    .ld(ld2), .sl(sl2), .iter_cnt(iter_cnt2), .q_shift(q_shift2),
    .div_zero(div_zero2), .quo_zero(quo_zero2), .res_valid(res_valid2),
    .res_ready(res_ready2)
  );

  function automatic int lzc(input logic [W-1:0] x);
    int n = 0;
    while (n < W && x[W-1-n] == 1'b0) n++;
    return n;
  endfunction

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int la, lb;
    logic [W-1:0] xn, yn;
    la = lzc(x);
    lb = lzc(y);
    xn = x << la;
    yn = y << lb;
    e.init = {xn, yn};
    e.dz = 1'b0; e.qz = 1'b0; e.qs = '0; e.nsl = 0; e.lat = 2;
    if (y == '0) e.dz = 1'b1;
    else if (lb < la) e.qz = 1'b1;
    else begin
      e.nsl = lb - la + 1;
      e.lat = e.nsl + 2;
      e.qs  = CW'(lb - la);
    end
    return e;
  endfunction

  // Issue one operation on the normalising unit and follow it to the handshake.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input int hold, input bit poke);
    exp_t e;
    int cyc = 0, nsl = 0, nld = 0;
    bit done = 0;
    sb.push_back(model(x, y));
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ld) begin
        nld++;
        checks++;
        if (cyc !== 1) begin errors++; $display("FAIL ld_cycle got %0d want 1", cyc); end
        checks++;
        if (init_val !== sb[0].init) begin
          errors++; $display("FAIL init_val got %h want %h", init_val, sb[0].init);
        end
      end
      if (sl) begin
        nsl++;
        if (nsl == 1) begin
          checks++;
          if (iter_cnt !== CW'(sb[0].nsl)) begin
            errors++; $display("FAIL iter_cnt_first got %0d want %0d", iter_cnt, sb[0].nsl);
          end
        end
      end
      if (res_valid) done = 1;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL res_valid_timeout got none want valid");
      return;
    end
    e = sb.pop_front();
    if (cyc !== e.lat) begin errors++; $display("FAIL latency got %0d want %0d", cyc, e.lat); end
    checks++;
    if (nld !== 1) begin errors++; $display("FAIL ld_count got %0d want 1", nld); end
    checks++;
    if (nsl !== e.nsl) begin errors++; $display("FAIL sl_count got %0d want %0d", nsl, e.nsl); end
    checks++;
    if ({div_zero, quo_zero} !== {e.dz, e.qz}) begin
      errors++; $display("FAIL flags got %b%b want %b%b", div_zero, quo_zero, e.dz, e.qz);
    end
    if (!e.dz && !e.qz) begin
      checks++;
      if (q_shift !== e.qs) begin errors++; $display("FAIL q_shift got %0d want %0d", q_shift, e.qs); end
    end
    checks++;
    if (iter_cnt !== '0) begin errors++; $display("FAIL iter_cnt_done got %0d want 0", iter_cnt); end
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({res_valid, busy, div_zero, quo_zero} !== {2'b11, e.dz, e.qz}) begin
        errors++; $display("FAIL hold_%0d got v%b b%b f%b%b want v1 b1 f%b%b",
                           h, res_valid, busy, div_zero, quo_zero, e.dz, e.qz);
      end
    end
    res_ready = 1'b1;
    start = poke;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    checks++;
    if ({busy, res_valid, div_zero, quo_zero} !== {2'b00, e.dz, e.qz}) begin
      errors++; $display("FAIL after_handshake got b%b v%b f%b%b want b0 v0 f%b%b",
                         busy, res_valid, div_zero, quo_zero, e.dz, e.qz);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0; a = '0; b = '0;
    start2 = 1'b0; abort2 = 1'b0; res_ready2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, ld, sl, res_valid, div_zero, quo_zero, iter_cnt, q_shift, init_val} !== '0) begin
      errors++; $display("FAIL reset_outputs got %b want 0",
        {busy, ld, sl, res_valid, div_zero, quo_zero, iter_cnt, q_shift, init_val});
    end
    checks++;
    if ({busy2, ld2, sl2, res_valid2, div_zero2, quo_zero2, iter_cnt2, q_shift2, init_val2} !== '0) begin
      errors++; $display("FAIL reset_outputs_nn got nonzero want 0");
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_op(8'd100, 8'd7, 0, 1'b0);
  endtask

  task automatic test_div_zero();
    run_op(8'h55, 8'h00, 0, 1'b0);
  endtask

  task automatic test_quo_zero();
    run_op(8'h03, 8'h40, 0, 1'b0);
    run_op(8'h00, 8'h05, 0, 1'b0);
  endtask

  task automatic test_table();
    logic [W-1:0] ta [5] = '{8'hFF, 8'h80, 8'h40, 8'h01, 8'hC3};
    logic [W-1:0] tb [5] = '{8'h01, 8'h80, 8'h03, 8'h01, 8'h11};
    for (int i = 0; i < 5; i++) run_op(ta[i], tb[i], i % 2, 1'b0);
  endtask

  task automatic test_backpressure();
    run_op(8'd100, 8'd7, 4, 1'b1);
  endtask

  task automatic test_abort();
    int nsl = 0;
    bit seen_valid = 0;
    @(negedge clk);
    a = 8'hFF; b = 8'h01; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 20 && nsl < 3; c++) begin
      @(negedge clk);
      if (sl) nsl++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, sl, ld, res_valid, iter_cnt} !== '0) begin
      errors++; $display("FAIL abort_outputs got b%b s%b l%b v%b cnt%0d want all 0",
                         busy, sl, ld, res_valid, iter_cnt);
    end
    repeat (10) begin
      @(negedge clk);
      if (res_valid || busy) seen_valid = 1;
    end
    checks++;
    if (seen_valid) begin errors++; $display("FAIL abort_idle got activity want idle"); end
    run_op(8'd100, 8'd7, 0, 1'b0);
  endtask

  task automatic test_rst_mid_iter();
    int c = 0;
    @(negedge clk);
    a = 8'hFF; b = 8'h01; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!sl && c < 10) begin @(negedge clk); c++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, ld, sl, res_valid, div_zero, quo_zero, iter_cnt, q_shift, init_val} !== '0) begin
      errors++; $display("FAIL rst_mid_iter got %b want 0",
        {busy, ld, sl, res_valid, div_zero, quo_zero, iter_cnt, q_shift, init_val});
    end
  endtask

  task automatic test_no_norm();
    int cyc = 0, nsl = 0;
    bit done = 0;
    @(negedge clk);
    a2 = 8'd9; b2 = 8'd3; start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ld2) begin
        checks++;
        if (init_val2 !== 16'h0903) begin
          errors++; $display("FAIL nn_init got %h want 0903", init_val2);
        end
      end
      if (sl2) nsl++;
      if (res_valid2) done = 1;
    end
    checks++;
    if (nsl !== 8) begin errors++; $display("FAIL nn_sl_count got %0d want 8", nsl); end
    checks++;
    if (cyc !== 10) begin errors++; $display("FAIL nn_latency got %0d want 10", cyc); end
    checks++;
    if ({q_shift2, div_zero2, quo_zero2} !== '0) begin
      errors++; $display("FAIL nn_qshift_flags got %h want 0", {q_shift2, div_zero2, quo_zero2});
    end
    res_ready2 = 1'b1;
    @(negedge clk);
    res_ready2 = 1'b0;
    checks++;
    if (busy2 !== 1'b0) begin errors++; $display("FAIL nn_idle got %b want 0", busy2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_quo_zero();
    test_table();
    test_backpressure();
    test_abort();
    test_rst_mid_iter();
    test_no_norm();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
